// File: rtl/bnn_seq_engine_pkg.sv
// Shared types and sizing helpers for the sequential BNN engine.
package bnn_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nibbles needed to carry W weight bits plus TH_W threshold bits.
  function automatic int rec_nib(input int w, input int th_w);
    return (w + th_w + NIBBLE_W - 1) / NIBBLE_W;
  endfunction

  function automatic int num_neurons(input int w, input int n_layers, input int n_out);
    return w * (n_layers - 1) + n_out;
  endfunction

  // Keeps counter widths at least one bit for degenerate sizes.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/bnn_seq_engine_if.sv
// Control, load and result signals of bnn_seq_engine.
// Optional class_idx output exists only when BNN_ARGMAX_EN is defined.
interface bnn_seq_engine_if #(
  parameter int W     = 8,
  parameter int N_OUT = 4
);
  localparam int CLS_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic             ena;
  logic             start;
  logic [W-1:0]     x_in;
  logic             load_start;
  logic             load_valid;
  logic [3:0]       load_data;
  logic             load_ready;
  logic             load_done;
  logic             busy;
  logic             out_valid;
  logic [N_OUT-1:0] y;
`ifdef BNN_ARGMAX_EN
  logic [CLS_W-1:0] class_idx;
`endif

  modport master (
    output ena, start, x_in, load_start, load_valid, load_data,
`ifdef BNN_ARGMAX_EN
    input  class_idx,
`endif
    input  load_ready, load_done, busy, out_valid, y
  );

  modport slave (
    input  ena, start, x_in, load_start, load_valid, load_data,
`ifdef BNN_ARGMAX_EN
    output class_idx,
`endif
    output load_ready, load_done, busy, out_valid, y
  );

endinterface

// File: rtl/bnn_seq_engine_neuron_eval.sv
// Combinational XNOR-popcount-threshold evaluation of one binary neuron.
module bnn_neuron_eval #(
  parameter int W    = 8,
  parameter int TH_W = $clog2(W + 1)
) (
  input  logic [W-1:0]    i_act,
  input  logic [W-1:0]    i_wgt,
  input  logic [TH_W-1:0] i_th,
  output logic [TH_W-1:0] o_pc,
  output logic            o_fire
);

  logic [TH_W-1:0] w_pc;

  // Popcount of agreeing activation/weight bits.
  always_comb begin
    w_pc = '0;
    for (int i = 0; i < W; i++) begin
      w_pc = w_pc + TH_W'(~(i_act[i] ^ i_wgt[i]));
    end
  end

  assign o_pc   = w_pc;
  assign o_fire = (w_pc >= i_th);

endmodule

// File: rtl/bnn_seq_engine.sv
// Time-multiplexed BNN: nibble-serial weight load, one neuron evaluated per cycle.
// Optional argmax output enabled by defining BNN_ARGMAX_EN.
module bnn_seq_engine
  import bnn_pkg::*;
#(
  parameter int W        = 8,
  parameter int N_LAYERS = 3,
  parameter int N_OUT    = 4
) (
  input logic              clk,
  input logic              rst_n,
  bnn_seq_engine_if.slave  bus
);

  localparam int TH_W    = $clog2(W + 1);
  localparam int REC_NIB = rec_nib(W, TH_W);
  localparam int REC_W   = REC_NIB * NIBBLE_W;
  localparam int NN      = num_neurons(W, N_LAYERS, N_OUT);
  localparam int IDX_W   = clog2_min1(NN);
  localparam int NIB_W   = clog2_min1(REC_NIB);
  localparam int LAY_W   = clog2_min1(N_LAYERS);
  localparam int N_W     = clog2_min1(W);
  localparam int CLS_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic [REC_W-1:0] r_rec [NN];
  logic [IDX_W-1:0] r_neu_ptr;
  logic [NIB_W-1:0] r_nib_ptr;
  logic             r_load_done;

  state_t           r_state;
  logic             r_busy;
  logic             r_out_valid;
  logic [N_OUT-1:0] r_y;
  logic [W-1:0]     r_act;
  logic [W-1:0]     r_nxt;
  logic [LAY_W-1:0] r_layer;
  logic [N_W-1:0]   r_n;

  logic [IDX_W-1:0] w_idx;
  logic [REC_W-1:0] w_rec;
  logic             w_fire;
  logic             w_accept;
  logic             w_last_layer;
  logic             w_last_n;
  logic [W-1:0]     w_nxt_fresh;
`ifdef BNN_ARGMAX_EN
  logic [TH_W-1:0]  w_pc;
  logic [TH_W-1:0]  r_best_pc;
  logic [CLS_W-1:0] r_best_idx;
  logic [CLS_W-1:0] r_class_idx;
`else
  logic [TH_W-1:0]  w_pc_unused;
`endif

  assign w_idx        = IDX_W'(r_layer) * IDX_W'(W) + IDX_W'(r_n);
  assign w_rec        = r_rec[w_idx];
  assign w_accept     = bus.ena & bus.load_valid & ~r_busy;
  assign w_last_layer = (r_layer == LAY_W'(N_LAYERS - 1));
  assign w_last_n     = w_last_layer ? (r_n == N_W'(N_OUT - 1)) : (r_n == N_W'(W - 1));

  // Next-layer vector including the bit being decided this cycle.
  always_comb begin
    w_nxt_fresh      = r_nxt;
    w_nxt_fresh[r_n] = w_fire;
  end

  bnn_neuron_eval #(.W(W), .TH_W(TH_W)) u_eval (
    .i_act  (r_act),
    .i_wgt  (w_rec[W-1:0]),
    .i_th   (w_rec[W+TH_W-1:W]),
`ifdef BNN_ARGMAX_EN
    .o_pc   (w_pc),
`else
    .o_pc   (w_pc_unused),
`endif
    .o_fire (w_fire)
  );

  // Record/pointer load protocol; load_start wins over a same-cycle beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NN; i++) r_rec[i] <= '0;
      r_neu_ptr   <= '0;
      r_nib_ptr   <= '0;
      r_load_done <= 1'b0;
    end else if (bus.ena && bus.load_start) begin
      r_neu_ptr   <= '0;
      r_nib_ptr   <= '0;
      r_load_done <= 1'b0;
    end else if (w_accept) begin
      r_rec[r_neu_ptr][int'(r_nib_ptr) * NIBBLE_W +: NIBBLE_W] <= bus.load_data;
      if (r_nib_ptr == NIB_W'(REC_NIB - 1)) begin
        r_nib_ptr <= '0;
        if (r_neu_ptr == IDX_W'(NN - 1)) begin
          r_neu_ptr   <= '0;
          r_load_done <= 1'b1;
        end else begin
          r_neu_ptr <= r_neu_ptr + IDX_W'(1);
        end
      end else begin
        r_nib_ptr <= r_nib_ptr + NIB_W'(1);
      end
    end
  end

  // Inference sequencer: IDLE -> RUN (one neuron per enabled cycle) -> DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_act       <= '0;
      r_nxt       <= '0;
      r_layer     <= '0;
      r_n         <= '0;
`ifdef BNN_ARGMAX_EN
      r_best_pc   <= '0;
      r_best_idx  <= '0;
      r_class_idx <= '0;
`endif
    end else if (bus.ena) begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_act   <= bus.x_in;
            r_nxt   <= '0;
            r_layer <= '0;
            r_n     <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_nxt[r_n] <= w_fire;
`ifdef BNN_ARGMAX_EN
          // Strict compare keeps the lowest index on ties.
          if (w_last_layer && ((r_n == '0) || (w_pc > r_best_pc))) begin
            r_best_pc  <= w_pc;
            r_best_idx <= CLS_W'(r_n);
          end
`endif
          if (w_last_layer && w_last_n) begin
            r_state <= DONE;
          end else if (w_last_n) begin
            r_act   <= w_nxt_fresh;
            r_layer <= r_layer + LAY_W'(1);
            r_n     <= '0;
          end else begin
            r_n <= r_n + N_W'(1);
          end
        end
        DONE: begin
          r_y         <= r_nxt[N_OUT-1:0];
          r_out_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
`ifdef BNN_ARGMAX_EN
          r_class_idx <= r_best_idx;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready = ~r_busy;
  assign bus.load_done  = r_load_done;
  assign bus.busy       = r_busy;
  assign bus.out_valid  = r_out_valid;
  assign bus.y          = r_y;
`ifdef BNN_ARGMAX_EN
  assign bus.class_idx  = r_class_idx;
`endif

endmodule
